// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one IDLE/LOCKED FSM per output with round-robin arbitration.
// An output stays locked to its winning input until that input's tail flit transfers.
module switch_allocator #(
  parameter int unsigned PORTS = 4,
  parameter int unsigned DW    = $clog2(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       req_valid,
  input  logic [PORTS*DW-1:0]    req_dst,
  input  logic [PORTS-1:0]       req_tail,
  input  logic [PORTS-1:0]       out_ack,
  output logic [PORTS-1:0]       out_en,
  output logic [PORTS*PORTS-1:0] sel,
  output logic [PORTS-1:0]       in_ack
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e        state_q [PORTS];
  logic [DW-1:0] owner_q [PORTS];
  logic [DW-1:0] ptr_q   [PORTS];

  logic [PORTS-1:0] in_locked;
  logic [PORTS-1:0] grant_valid;
  logic [DW-1:0]    grant_idx [PORTS];
  logic [PORTS-1:0] tail_done;

  always_comb begin : lock_map
    in_locked = '0;
    for (int o = 0; o < int'(PORTS); o++) begin
      if (state_q[o] == StLocked) in_locked[owner_q[o]] = 1'b1;
    end
  end

  always_comb begin : datapath
    out_en    = '0;
    sel       = '0;
    in_ack    = '0;
    tail_done = '0;
    for (int o = 0; o < int'(PORTS); o++) begin
      if (state_q[o] == StLocked) begin
        sel[o*int'(PORTS) + int'(owner_q[o])] = 1'b1;
        out_en[o] = req_valid[owner_q[o]];
        if (req_valid[owner_q[o]] && out_ack[o]) begin
          in_ack[owner_q[o]] = 1'b1;
          tail_done[o]       = req_tail[owner_q[o]];
        end
      end
    end
  end

  // Destinations >= PORTS never match any output index, so they are ignored.
  always_comb begin : arbiter
    int idx;
    idx         = 0;
    grant_valid = '0;
    for (int o = 0; o < int'(PORTS); o++) begin
      grant_idx[o] = '0;
      for (int k = 0; k < int'(PORTS); k++) begin
        idx = (int'(ptr_q[o]) + k) % int'(PORTS);
        if (!grant_valid[o] && req_valid[idx] && !in_locked[idx] &&
            int'(req_dst[idx*int'(DW) +: DW]) == o) begin
          grant_valid[o] = 1'b1;
          grant_idx[o]   = DW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < int'(PORTS); o++) begin
        state_q[o] <= StIdle;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < int'(PORTS); o++) begin
        case (state_q[o])
          StIdle: begin
            if (grant_valid[o]) begin
              state_q[o] <= StLocked;
              owner_q[o] <= grant_idx[o];
            end
          end
          StLocked: begin
            // Pointer only advances on tail release, just past the finished owner.
            if (tail_done[o]) begin
              state_q[o] <= StIdle;
              ptr_q[o]   <= DW'((int'(owner_q[o]) + 1) % int'(PORTS));
            end
          end
          default: state_q[o] <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: upstream packet model per input plus a
// scoreboard of expected (output, input) flit transfers in order.
module tb_switch_allocator;
  localparam int P  = 4;
  localparam int DW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [P-1:0]   req_valid, req_tail, out_ack, out_en, in_ack;
  logic [P*DW-1:0] req_dst;
  logic [P*P-1:0] sel;

  int         rem [P];
  int         dst [P];
  logic [P-1:0] hold;
  logic [P-1:0] ack_lat;

  typedef struct {int o; int i;} xfer_t;
  xfer_t exp_q[$];

  int checks = 0;
  int errors = 0;

  switch_allocator #(.PORTS(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dst   (req_dst),
    .req_tail  (req_tail),
    .out_ack   (out_ack),
    .out_en    (out_en),
    .sel       (sel),
    .in_ack    (in_ack)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_tail  = '0;
    req_dst   = '0;
    for (int i = 0; i < P; i++) begin
      req_valid[i]          = (rem[i] > 0) && !hold[i];
      req_tail[i]           = (rem[i] == 1);
      req_dst[i*DW +: DW]   = DW'(dst[i]);
    end
  end

  // Monitor: every transfer pops the scoreboard and must match output and source.
  always @(negedge clk) begin
    int act;
    xfer_t e;
    ack_lat <= in_ack;
    for (int o = 0; o < P; o++) begin
      if (out_en[o] && out_ack[o]) begin
        act = -1;
        for (int i = 0; i < P; i++) if (sel[o*P+i]) act = i;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected out=%0d in=%0d required no transfer", o, act);
        end else begin
          e = exp_q.pop_front();
          if (e.o != o || e.i != act || !in_ack[e.i]) begin
            errors++;
            $display("FAIL xfer out=%0d in=%0d in_ack=%b required out=%0d in=%0d",
                     o, act, in_ack, e.o, e.i);
          end
        end
      end
    end
  end

  // Upstream advances one flit after each acknowledged edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < P; i++) if (ack_lat[i] && rem[i] > 0) rem[i]--;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_xfer(input int o, input int i, input int n);
    xfer_t e;
    e.o = o;
    e.i = i;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic run_until_idle(input int budget, output int cycles, output bit timeout);
    bit busy;
    cycles  = 0;
    timeout = 1'b0;
    forever begin
      busy = 1'b0;
      for (int i = 0; i < P; i++) if (rem[i] > 0) busy = 1'b1;
      if (!busy) break;
      if (cycles >= budget) begin
        timeout = 1'b1;
        break;
      end
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < P; i++) begin
      rem[i] = 0;
      dst[i] = 0;
    end
    hold    = '0;
    out_ack = '1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_en !== '0 || in_ack !== '0 || sel !== '0) begin
      errors++;
      $display("FAIL reset_outputs out_en=%b in_ack=%b sel=%h required all zero",
               out_en, in_ack, sel);
    end
    rem[1] = 1;
    dst[1] = 2;
    step();
    step();
    checks++;
    if (out_en !== '0 || sel !== '0) begin
      errors++;
      $display("FAIL reset_hold out_en=%b sel=%h required zero", out_en, sel);
    end
    rem[1] = 0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_single_flit();
    step();
    rem[1] = 1;
    dst[1] = 2;
    push_xfer(2, 1, 1);
    @(negedge clk);
    checks++;
    if (out_en !== 4'b0000) begin
      errors++;
      $display("FAIL single_same_cycle out_en=%b required 0000", out_en);
    end
    step();
    @(negedge clk);
    checks++;
    if (sel[2*P +: P] !== 4'b0010 || out_en !== 4'b0100 || in_ack !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant sel2=%b out_en=%b in_ack=%b required 0010 0100 0010",
               sel[2*P +: P], out_en, in_ack);
    end
    step();
    @(negedge clk);
    checks++;
    if (out_en !== 4'b0000 || sel !== '0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_release out_en=%b sel=%h pending=%0d required 0000 0 0",
               out_en, sel, exp_q.size());
    end
  endtask

  task automatic contend(input int a, input int b, input int c);
    int  cycles;
    bit  to;
    step();
    rem[0] = 3; dst[0] = 2;
    rem[1] = 3; dst[1] = 2;
    rem[3] = 3; dst[3] = 2;
    push_xfer(2, a, 3);
    push_xfer(2, b, 3);
    push_xfer(2, c, 3);
    run_until_idle(40, cycles, to);
    checks++;
    if (to || cycles != 12 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL contention_timing cycles=%0d timeout=%0b pending=%0d required 12 0 0",
               cycles, to, exp_q.size());
    end
  endtask

  task automatic test_contention();
    // Pointer of output 2 sits at 2 after the single-flit packet from input 1.
    contend(3, 0, 1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    contend(0, 1, 3);
  endtask

  task automatic test_backpressure();
    int cycles;
    bit to;
    step();
    out_ack[1] = 1'b0;
    rem[0] = 3;
    dst[0] = 1;
    push_xfer(1, 0, 3);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_en[1] !== 1'b1 || in_ack[0] !== 1'b0 || sel[1*P +: P] !== 4'b0001) begin
        errors++;
        $display("FAIL backpressure_stall k=%0d out_en=%b in_ack=%b sel1=%b required 1 0 0001",
                 k, out_en, in_ack, sel[1*P +: P]);
      end
      step();
    end
    hold[0]    = 1'b1;
    out_ack[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (out_en[1] !== 1'b0 || in_ack !== 4'b0000 || sel[1*P +: P] !== 4'b0001) begin
      errors++;
      $display("FAIL valid_stall out_en=%b in_ack=%b sel1=%b required 0 0000 0001",
               out_en, in_ack, sel[1*P +: P]);
    end
    step();
    hold[0] = 1'b0;
    run_until_idle(20, cycles, to);
    checks++;
    if (to || cycles != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure_resume cycles=%0d timeout=%0b pending=%0d required 3 0 0",
               cycles, to, exp_q.size());
    end
  endtask

  task automatic test_parallel();
    int cycles;
    bit to;
    step();
    rem[0] = 2; dst[0] = 3;
    rem[2] = 2; dst[2] = 1;
    push_xfer(1, 2, 1);
    push_xfer(3, 0, 1);
    push_xfer(1, 2, 1);
    push_xfer(3, 0, 1);
    step();
    @(negedge clk);
    checks++;
    if (out_en !== 4'b1010 || in_ack !== 4'b0101) begin
      errors++;
      $display("FAIL parallel_grant out_en=%b in_ack=%b required 1010 0101", out_en, in_ack);
    end
    run_until_idle(20, cycles, to);
    checks++;
    if (to || cycles != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL parallel_done cycles=%0d timeout=%0b pending=%0d required 2 0 0",
               cycles, to, exp_q.size());
    end
  endtask

  task automatic test_locked_exclusion();
    step();
    rem[2] = 3;
    dst[2] = 0;
    push_xfer(0, 2, 3);
    step();
    dst[2] = 3;
    for (int k = 0; k < 8 && rem[2] > 0; k++) begin
      @(negedge clk);
      checks++;
      if (out_en[3] !== 1'b0 || sel[3*P +: P] !== 4'b0000) begin
        errors++;
        $display("FAIL locked_excl k=%0d out_en3=%b sel3=%b required 0 0000",
                 k, out_en[3], sel[3*P +: P]);
      end
      step();
    end
    rem[2] = 1;
    push_xfer(3, 2, 1);
    step();
    @(negedge clk);
    checks++;
    if (out_en[3] !== 1'b1 || sel[3*P +: P] !== 4'b0100) begin
      errors++;
      $display("FAIL released_eligible out_en3=%b sel3=%b required 1 0100",
               out_en[3], sel[3*P +: P]);
    end
    step();
    checks++;
    if (exp_q.size() != 0 || rem[2] != 0) begin
      errors++;
      $display("FAIL locked_excl_done pending=%0d rem2=%0d required 0 0", exp_q.size(), rem[2]);
    end
  endtask

  task automatic test_reset_mid_packet();
    int cycles;
    bit to;
    step();
    rem[1] = 3;
    dst[1] = 0;
    push_xfer(0, 1, 3);
    step();
    step();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_en !== '0 || in_ack !== '0 || sel !== '0) begin
      errors++;
      $display("FAIL reset_async out_en=%b in_ack=%b sel=%h required all zero",
               out_en, in_ack, sel);
    end
    rem[1] = 0;
    exp_q.delete();
    step();
    rst = 1'b1;
    // Output 0 pointer was 3 before reset; cleared pointer must favour input 1.
    rem[1] = 1; dst[1] = 0;
    rem[3] = 1; dst[3] = 0;
    push_xfer(0, 1, 1);
    push_xfer(0, 3, 1);
    run_until_idle(20, cycles, to);
    checks++;
    if (to || cycles != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_rearb cycles=%0d timeout=%0b pending=%0d required 4 0 0",
               cycles, to, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_contention();
    test_backpressure();
    test_parallel();
    test_locked_exclusion();
    test_reset_mid_packet();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter PORTS, default 4: number of router ports (N/E/S/W); crossbar is PORTS x PORTS.
REQ-002 Parameter DW = $clog2(PORTS), derived: width of one output-port index.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  PORTS  bit i: input port i holds a flit (header or body) ready to forward.
REQ-006 req_dst  input  PORTS*DW  field i: output port requested by input i; sampled only while input i is unlocked (header flit).
REQ-007 req_tail  input  PORTS  bit i: flit at input i is TAIL (single-flit packets assert it on the header).
REQ-008 out_ack  input  PORTS  bit o: downstream node accepts the flit on output o this cycle.
REQ-009 out_en  output  PORTS  bit o: output o carries a valid flit this cycle.
REQ-010 sel  output  PORTS*PORTS  row o: one-hot input index driving output o (crossbar dest); all-zero when unowned.
REQ-011 in_ack  output  PORTS  bit i: flit at input i transferred this cycle; upstream advances.

Function
REQ-012 Each output o SHALL have a state machine IDLE/LOCKED, a DW-bit owner register and a DW-bit round-robin pointer ptr[o].
REQ-013 An input i SHALL be "locked" iff some output is LOCKED with owner==i; an input SHALL own at most one output.
REQ-014 In IDLE, candidates for output o SHALL be inputs i with req_valid[i]=1, req_dst[i]==o, i unlocked; req_dst values >= PORTS SHALL be ignored.
REQ-015 Arbitration SHALL grant the first candidate searching ptr[o], ptr[o]+1, ... modulo PORTS; at the edge, state->LOCKED, owner<=winner.
REQ-016 Grant latency: request visible in cycle N -> sel row and out_en valid in cycle N+1; no same-cycle forwarding.
REQ-017 While LOCKED: sel[o] = onehot(owner); out_en[o] = req_valid[owner]; in_ack[owner] = out_en[o] & out_ack[o]; all combinational.
REQ-018 Transfer on output o occurs when out_en[o] & out_ack[o]; no flit is dropped or duplicated.
REQ-019 Transfer with req_tail[owner]=1 SHALL, at that edge, set state->IDLE, ptr[o]<=(owner+1) mod PORTS, clear sel row.
REQ-020 Released output SHALL re-arbitrate starting the cycle after release (one idle cycle between packets on same output).
REQ-021 Deasserted out_ack or req_valid while LOCKED SHALL stall (out_en/in_ack low as per REQ-017) and keep the lock indefinitely.
REQ-022 Different outputs SHALL allocate independently and concurrently in the same cycle.
REQ-023 Input released by tail at edge N SHALL be eligible to win a new output in arbitration of cycle N+1.
REQ-024 in_ack[i] SHALL be 0 for every unlocked input; out_en[o] SHALL be 0 in IDLE.
REQ-025 ptr[o] SHALL change only on tail release, never on grant or stall.

Reset
REQ-026 rst low SHALL immediately (asynchronously) force all outputs IDLE, owner=0, ptr=0, out_en=0, in_ack=0, sel=0.
REQ-027 Reset mid-packet SHALL abandon the packet; after rst rises, first edge arbitrates from ptr=0 with no residual lock.

Verification
REQ-028 Single flit: input 1 req_valid=1, req_dst=2, req_tail=1, out_ack[2]=1 -> cycle+1 sel[2]=0010, out_en[2]=1, in_ack[1]=1; cycle+2 output 2 IDLE, ptr[2]=2.
REQ-029 Contention: inputs 0,1,3 all request output 2, 3-flit packets, out_ack=1 -> owners in order 0,1,3, each packet contiguous, one idle cycle between.
REQ-030 Backpressure: input 0 locked on output 1, out_ack[1]=0 for 5 cycles -> out_en[1]=1, in_ack[0]=0 throughout; lock held; resumes on ack.
REQ-031 Parallel: input 0->out 3, input 2->out 1 same cycle -> both granted next cycle, independent transfers.
REQ-032 Reset mid-packet: rst low during body flit -> out_en, in_ack, sel zero without clock edge; new header after release granted with ptr=0.
REQ-033 Locked-input exclusion: input 2 locked on out 0 presents req_dst=3 -> never granted out 3 until its tail transfers.
